// File: rtl/md_sched.sv
// HI/LO multiply-divide scheduler: a busy-counter FSM that models the latency of
// mult/div, commits results into the HI/LO registers and raises the ID/IF stall.
module md_sched #(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        id_md,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV
    } state_t;

    localparam logic [3:0] MUL_CNT = 4'(MUL_LAT);
    localparam logic [3:0] DIV_CNT = 4'(DIV_LAT);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    state_t      state, state_n;
    logic [3:0]  cnt, cnt_n;
    logic [31:0] opa, opa_n;
    logic [31:0] opb, opb_n;
    logic        sgn, sgn_n;
    logic [31:0] hi_n, lo_n;

    logic [63:0] ext_a, ext_b, prod;
    logic [31:0] mag_a, mag_b, quo, rem, quo_s, rem_s;
    logic        neg_a, neg_b, div_zero, long_op;

    // Operands come only from the copies latched at start, never from a/b.
    // Division runs on magnitudes so the 0x80000000 / -1 overflow case falls
    // out naturally as quotient 0x80000000, remainder 0.
    always_comb begin
        neg_a    = sgn & opa[31];
        neg_b    = sgn & opb[31];
        ext_a    = {{32{neg_a}}, opa};
        ext_b    = {{32{neg_b}}, opb};
        prod     = ext_a * ext_b;
        mag_a    = neg_a ? (32'd0 - opa) : opa;
        mag_b    = neg_b ? (32'd0 - opb) : opb;
        div_zero = (opb == 32'd0);
        quo      = div_zero ? 32'd0 : (mag_a / mag_b);
        rem      = div_zero ? 32'd0 : (mag_a % mag_b);
        quo_s    = (neg_a ^ neg_b) ? (32'd0 - quo) : quo;
        rem_s    = neg_a ? (32'd0 - rem) : rem;
    end

    assign busy    = (state == MUL) || (state == DIV);
    assign long_op = (op >= OP_MULT) && (op <= OP_DIVU);
    assign stall   = id_md & (busy | (long_op & ~req));

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        opa_n   = opa;
        opb_n   = opb;
        sgn_n   = sgn;
        hi_n    = hi;
        lo_n    = lo;
        case (state)
            IDLE: begin
                if (!req) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            opa_n   = a;
                            opb_n   = b;
                            sgn_n   = (op == OP_MULT);
                            cnt_n   = MUL_CNT;
                            state_n = MUL;
                        end
                        OP_DIV, OP_DIVU: begin
                            opa_n   = a;
                            opb_n   = b;
                            sgn_n   = (op == OP_DIV);
                            cnt_n   = DIV_CNT;
                            state_n = DIV;
                        end
                        OP_MTHI: hi_n = a;
                        OP_MTLO: lo_n = a;
                        default: ;
                    endcase
                end
            end
            MUL: begin
                if (cnt == 4'd1) begin
                    hi_n    = prod[63:32];
                    lo_n    = prod[31:0];
                    cnt_n   = 4'd0;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            DIV: begin
                if (cnt == 4'd1) begin
                    if (!div_zero) begin
                        hi_n = rem_s;
                        lo_n = quo_s;
                    end
                    cnt_n   = 4'd0;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            default: begin
                cnt_n   = 4'd0;
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
            opa   <= 32'd0;
            opb   <= 32'd0;
            sgn   <= 1'b0;
            hi    <= 32'd0;
            lo    <= 32'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            opa   <= opa_n;
            opb   <= opb_n;
            sgn   <= sgn_n;
            hi    <= hi_n;
            lo    <= lo_n;
        end
    end

endmodule

// File: tb/tb_md_sched.sv
// Directed bench for md_sched: a vector table of single operations followed by
// hand-written sequences for stall, req-during-busy and mid-operation reset.
module tb_md_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        id_md;
    logic        busy, stall;
    logic [31:0] hi, lo;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        req;
        int          exp_busy;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[15];

    md_sched #(.MUL_LAT(5), .DIV_LAT(10)) dut (
        .clk(clk), .rst(rst), .req(req), .op(op), .a(a), .b(b),
        .id_md(id_md), .busy(busy), .stall(stall), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op for a cycle, then scramble a/b and count busy cycles (bounded).
    task automatic applyStimulus(input vec_t v, output int nbusy);
        op = v.op; a = v.a; b = v.b; req = v.req;
        tick();
        op = 3'd0; req = 1'b0;
        nbusy = 0;
        while (busy && nbusy < 20) begin
            a = $urandom; b = $urandom;
            nbusy++;
            tick();
        end
    endtask

    initial begin
        int nb;

        vecs[0]  = '{"mult_neg1x2",   3'd1, 32'hFFFFFFFF, 32'd2,        1'b0, 5,  32'hFFFFFFFF, 32'hFFFFFFFE};
        vecs[1]  = '{"multu_ffx2",    3'd2, 32'hFFFFFFFF, 32'd2,        1'b0, 5,  32'h00000001, 32'hFFFFFFFE};
        vecs[2]  = '{"div_m7_2",      3'd3, 32'hFFFFFFF9, 32'd2,        1'b0, 10, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{"divu_7_2",      3'd4, 32'd7,        32'd2,        1'b0, 10, 32'h00000001, 32'h00000003};
        vecs[4]  = '{"mult_req",      3'd1, 32'd5,        32'd5,        1'b1, 0,  32'h00000001, 32'h00000003};
        vecs[5]  = '{"mthi",          3'd5, 32'h1234,     32'd0,        1'b0, 0,  32'h00001234, 32'h00000003};
        vecs[6]  = '{"mtlo",          3'd6, 32'hABCD,     32'd0,        1'b0, 0,  32'h00001234, 32'h0000ABCD};
        vecs[7]  = '{"div_overflow",  3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, 10, 32'h00000000, 32'h80000000};
        vecs[8]  = '{"div_by_zero",   3'd3, 32'd55,       32'd0,        1'b0, 10, 32'h00000000, 32'h80000000};
        vecs[9]  = '{"div_7_m2",      3'd3, 32'd7,        32'hFFFFFFFE, 1'b0, 10, 32'h00000001, 32'hFFFFFFFD};
        vecs[10] = '{"divu_big",      3'd4, 32'hFFFFFFFF, 32'h10,       1'b0, 10, 32'h0000000F, 32'h0FFFFFFF};
        vecs[11] = '{"mult_min_sq",   3'd1, 32'h80000000, 32'h80000000, 1'b0, 5,  32'h40000000, 32'h00000000};
        vecs[12] = '{"multu_ff_sq",   3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 5,  32'hFFFFFFFE, 32'h00000001};
        vecs[13] = '{"mult_m3x5",     3'd1, 32'hFFFFFFFD, 32'd5,        1'b0, 5,  32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[14] = '{"mthi_req",      3'd5, 32'h5555,     32'd0,        1'b1, 0,  32'hFFFFFFFF, 32'hFFFFFFF1};

        rst = 1'b1; req = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0; id_md = 1'b0;
        tick();
        tick();
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_hi", hi, 32'd0);
        checkOutput("reset_lo", lo, 32'd0);
        id_md = 1'b1; op = 3'd1; #1;
        checkOutput("reset_stall_mult", {31'd0, stall}, 32'd1);
        op = 3'd5; #1;
        checkOutput("reset_stall_mthi", {31'd0, stall}, 32'd0);
        op = 3'd3; req = 1'b1; #1;
        checkOutput("reset_stall_req", {31'd0, stall}, 32'd0);
        rst = 1'b0; op = 3'd0; req = 1'b0; id_md = 1'b0;
        tick();

        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i], nb);
            checkOutput({vecs[i].name, "_busy"}, nb, vecs[i].exp_busy);
            checkOutput({vecs[i].name, "_hi"}, hi, vecs[i].exp_hi);
            checkOutput({vecs[i].name, "_lo"}, lo, vecs[i].exp_lo);
        end

        // Ops during busy are ignored while stall stays high; 100/7 -> q=14, r=2.
        id_md = 1'b1; op = 3'd3; a = 32'd100; b = 32'd7;
        tick();
        nb = 0;
        a = 32'd1; b = 32'd1;
        while (busy && nb < 20) begin
            checkOutput("busy_stall", {31'd0, stall}, 32'd1);
            nb++;
            tick();
        end
        checkOutput("busyop_count", nb, 10);
        checkOutput("busyop_hi", hi, 32'd2);
        checkOutput("busyop_lo", lo, 32'd14);
        op = 3'd0; #1;
        checkOutput("idle_stall", {31'd0, stall}, 32'd0);
        id_md = 1'b0;
        tick();

        // req raised mid-operation must not disturb the running multiply.
        op = 3'd1; a = 32'd3; b = 32'd4;
        tick();
        op = 3'd0; req = 1'b1;
        nb = 0;
        while (busy && nb < 20) begin
            nb++;
            tick();
        end
        req = 1'b0;
        checkOutput("reqbusy_count", nb, 5);
        checkOutput("reqbusy_hi", hi, 32'd0);
        checkOutput("reqbusy_lo", lo, 32'd12);

        // Reset in the third busy cycle of a divide aborts it with no write.
        op = 3'd3; a = 32'd9; b = 32'd2;
        tick();
        op = 3'd0;
        checkOutput("rstmid_busy1", {31'd0, busy}, 32'd1);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("rstmid_busy", {31'd0, busy}, 32'd0);
        checkOutput("rstmid_hi", hi, 32'd0);
        checkOutput("rstmid_lo", lo, 32'd0);
        for (int i = 0; i < 15; i++) tick();
        checkOutput("rstmid_late_busy", {31'd0, busy}, 32'd0);
        checkOutput("rstmid_late_hi", hi, 32'd0);
        checkOutput("rstmid_late_lo", lo, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
